// File: rtl/fp_align.sv
// rtl/fp_align.sv - single-precision operand alignment ahead of a floating-point adder
module fp_align (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_exp,
    output logic [27:0] o_mant_big,
    output logic [27:0] o_mant_small,
    output logic        o_sign_big,
    output logic        o_sign_small,
    output logic        o_swap,
    output logic        o_special
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [7:0]  r_exp;
    logic [27:0] r_mant_big;
    logic [27:0] r_mant_small;
    logic        r_sign_big;
    logic        r_sign_small;
    logic        r_swap;
    logic        r_special;

    logic [7:0]  w_e_a;
    logic [7:0]  w_e_b;
    logic [27:0] w_m_a;
    logic [27:0] w_m_b;
    logic        w_b_big;
    logic [7:0]  w_e_big;
    logic [7:0]  w_e_small;
    logic [27:0] w_m_big;
    logic [27:0] w_m_small;
    logic [7:0]  w_d;
    logic        w_special;
    logic        w_accept;
    logic        w_direct;

    // Denormals and zeros behave as exponent 1 with no hidden bit.
    assign w_e_a = (i_a[30:23] == 8'd0) ? 8'd1 : i_a[30:23];
    assign w_e_b = (i_b[30:23] == 8'd0) ? 8'd1 : i_b[30:23];
    assign w_m_a = {1'b0, (i_a[30:23] != 8'd0), i_a[22:0], 3'b000};
    assign w_m_b = {1'b0, (i_b[30:23] != 8'd0), i_b[22:0], 3'b000};

    // On a full tie operand a stays big.
    assign w_b_big   = (w_e_b > w_e_a) || ((w_e_b == w_e_a) && (w_m_b > w_m_a));
    assign w_e_big   = w_b_big ? w_e_b : w_e_a;
    assign w_e_small = w_b_big ? w_e_a : w_e_b;
    assign w_m_big   = w_b_big ? w_m_b : w_m_a;
    assign w_m_small = w_b_big ? w_m_a : w_m_b;
    assign w_d       = w_e_big - w_e_small;
    assign w_special = (i_a[30:23] == 8'hFF) || (i_b[30:23] == 8'hFF);
    assign w_accept  = i_valid && (r_state == IDLE);
    assign w_direct  = w_special || (w_d == 8'd0) || (w_d >= 8'd27);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_next = w_direct ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt <= 5'd1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= 5'd0;
            r_exp        <= 8'd0;
            r_mant_big   <= 28'd0;
            r_mant_small <= 28'd0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_swap       <= 1'b0;
            r_special    <= 1'b0;
        end else if (w_accept) begin
            r_exp        <= w_e_big;
            r_mant_big   <= w_m_big;
            r_sign_big   <= w_b_big ? i_b[31] : i_a[31];
            r_sign_small <= w_b_big ? i_a[31] : i_b[31];
            r_swap       <= w_b_big;
            r_special    <= w_special;
            if (!w_special && (w_d >= 8'd27)) begin
                r_mant_small <= {27'd0, |w_m_small};
                r_cnt        <= 5'd0;
            end else if (w_direct) begin
                r_mant_small <= w_m_small;
                r_cnt        <= 5'd0;
            end else begin
                r_mant_small <= w_m_small;
                r_cnt        <= w_d[4:0];
            end
        end else if (r_state == SHIFT) begin
            // One position per edge; the bit falling off folds into the sticky bit.
            r_mant_small <= {1'b0, r_mant_small[27:2], r_mant_small[1] | r_mant_small[0]};
            r_cnt        <= r_cnt - 5'd1;
        end
    end

    assign o_ready      = (r_state == IDLE);
    assign o_valid      = (r_state == DONE);
    assign o_exp        = r_exp;
    assign o_mant_big   = r_mant_big;
    assign o_mant_small = r_mant_small;
    assign o_sign_big   = r_sign_big;
    assign o_sign_small = r_sign_small;
    assign o_swap       = r_swap;
    assign o_special    = r_special;

endmodule

// File: tb/tb_fp_align.sv
// tb/tb_fp_align.sv - randomized self-checking bench for fp_align against an arithmetic model
module tb_fp_align;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_exp;
    logic [27:0] o_mant_big;
    logic [27:0] o_mant_small;
    logic        o_sign_big;
    logic        o_sign_small;
    logic        o_swap;
    logic        o_special;

    int n_pass;
    int n_total;

    fp_align dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_exp        (o_exp),
        .o_mant_big   (o_mant_big),
        .o_mant_small (o_mant_small),
        .o_sign_big   (o_sign_big),
        .o_sign_small (o_sign_small),
        .o_swap       (o_swap),
        .o_special    (o_special)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Significands compared as integers keyed by (effective exponent, significand).
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [7:0] e, output logic [27:0] mb,
                                  output logic [27:0] ms, output logic sb,
                                  output logic ss, output logic sw,
                                  output logic sp, output int lat);
        longint ea, eb, sa, sbig, key_a, key_b, ebig, esml, ssml, d, mant_s, res;
        ea    = (a[30:23] == 0) ? 1 : longint'(a[30:23]);
        eb    = (b[30:23] == 0) ? 1 : longint'(b[30:23]);
        sa    = ((a[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0]);
        sbig  = ((b[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0]);
        key_a = ea * 16777216 + sa;
        key_b = eb * 16777216 + sbig;
        sw    = (key_b > key_a);
        ebig  = sw ? eb : ea;
        esml  = sw ? ea : eb;
        ssml  = sw ? sa : sbig;
        mb    = 28'((sw ? sbig : sa) * 8);
        sb    = sw ? b[31] : a[31];
        ss    = sw ? a[31] : b[31];
        e     = 8'(ebig);
        sp    = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        d     = ebig - esml;
        mant_s = ssml * 8;
        if (sp || d == 0) begin
            res = mant_s;
        end else if (d >= 27) begin
            res = (mant_s != 0) ? 1 : 0;
        end else begin
            res = (mant_s >> d) | (((mant_s % (64'd1 << d)) != 0) ? 1 : 0);
        end
        ms  = 28'(res);
        lat = (sp || d == 0 || d >= 27) ? 0 : int'(d);
    endfunction

    task automatic check_outputs(input string tag, input logic [7:0] e, input logic [27:0] mb,
                                 input logic [27:0] ms, input logic sb, input logic ss,
                                 input logic sw, input logic sp);
        chk({tag, "_exp"}, 64'(o_exp), 64'(e));
        chk({tag, "_mbig"}, 64'(o_mant_big), 64'(mb));
        chk({tag, "_msmall"}, 64'(o_mant_small), 64'(ms));
        chk({tag, "_signs"}, 64'({o_sign_big, o_sign_small}), 64'({sb, ss}));
        chk({tag, "_swap_spec"}, 64'({o_swap, o_special}), 64'({sw, sp}));
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [7:0]  e;
        logic [27:0] mb, ms;
        logic        sb, ss, sw, sp;
        int          lat, n, w;
        model(a, b, e, mb, ms, sb, ss, sw, sp, lat);
        @(negedge i_clk);
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        chk("ready_idle", 64'(o_ready), 64'd1);
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        n = 0;
        while (!o_valid && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        check_outputs("done", e, mb, ms, sb, ss, sw, sp);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            i_a     = $urandom;
            i_b     = $urandom;
            @(posedge i_clk);
            #1;
            chk("hold_handshake", 64'({o_valid, o_ready}), 64'b10);
            check_outputs("hold", e, mb, ms, sb, ss, sw, sp);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("release", 64'({o_valid, o_ready}), 64'b01);
        i_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand(input int mode, input logic [7:0] ref_exp);
        logic [7:0] ex;
        int         t;
        case (mode)
            0: ex = 8'd0;
            1: ex = 8'hFF;
            2: ex = 8'($urandom_range(0, 254));
            default: begin
                t = int'(ref_exp) + int'($urandom_range(0, 34)) - 17;
                if (t < 0) t = 0;
                if (t > 254) t = 254;
                ex = 8'(t);
            end
        endcase
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int          w;
        n_pass  = 0;
        n_total = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_handshake", 64'({o_valid, o_ready}), 64'b01);
        chk("rst_data", 64'({o_exp, o_mant_big, o_mant_small} != 0), 64'd0);
        chk("rst_flags", 64'({o_sign_big, o_sign_small, o_swap, o_special}), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        txn(32'h3F800000, 32'h3F800000, 0);
        txn(32'h3F800000, 32'h40400000, 1);
        txn(32'h41800000, 32'h3F800001, 0);
        txn(32'h4F800000, 32'h3F800000, 0);
        txn(32'h7F800000, 32'h12345678, 5);
        txn(32'h00000003, 32'h00000005, 0);
        txn(32'h80000000, 32'h00000000, 0);

        // Abort a d=20 alignment five edges into SHIFT.
        @(negedge i_clk);
        i_a     = 32'h49800000;
        i_b     = 32'h3F800000;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        chk("pre_abort_busy", 64'({o_valid, o_ready}), 64'b00);
        i_rst = 1'b1;
        #1;
        chk("abort_handshake", 64'({o_valid, o_ready}), 64'b01);
        chk("abort_data", 64'({o_exp, o_mant_big, o_mant_small} != 0), 64'd0);
        chk("abort_flags", 64'({o_sign_big, o_sign_small, o_swap, o_special}), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        txn(32'h40000000, 32'hC0000000, 0);

        for (int i = 0; i < 150; i++) begin
            ra = rand_operand(($urandom_range(0, 19) == 0) ? 1 :
                              ($urandom_range(0, 9) == 0) ? 0 : 2, 8'd0);
            rb = rand_operand(($urandom_range(0, 24) == 0) ? 1 :
                              ($urandom_range(0, 9) == 0) ? 0 : 3, ra[30:23]);
            if ($urandom_range(0, 15) == 0) rb = ra;
            txn(ra, rb, int'($urandom_range(0, 2)));
        end

        w = 0;
        while (!o_ready && w < 10) begin
            @(posedge i_clk);
            w++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
